// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider and the controller logic that
// issues DIV/DIVU to it.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU in the execute stage.
// Holds the pipeline through stall_divE until {HI,LO} is valid.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_divE
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0]    dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]  result_q, result_d;

  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    a_abs, b_abs;
  logic [WIDTH:0]      shift_rem, trial;
  logic [WIDTH-1:0]    step_rem, step_quo;

  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  // One restoring step: a negative trial (top bit set) keeps the old remainder.
  assign shift_rem = {rem_q, quo_q[WIDTH-1]};
  assign trial     = shift_rem - {1'b0, dvs_q};
  assign step_rem  = trial[WIDTH] ? shift_rem[WIDTH-1:0] : trial[WIDTH-1:0];
  assign step_quo  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (start && !annul) begin
          if (b == '0) begin
            result_d = {a, {WIDTH{1'b1}}};
            state_d  = DIV_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = a_abs;
            dvs_d     = b_abs;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            state_d   = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          result_d = {neg_rem_q ? -step_rem : step_rem,
                      neg_quo_q ? -step_quo : step_quo};
          state_d  = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    // A flush abandons the divide without touching HI/LO.
    if (annul) begin
      state_d  = DIV_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign result     = result_q;
  assign ready      = (state_q == DIV_DONE);
  assign stall_divE = start & ~ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, stall window, signed fix-up,
// divide-by-zero, annul, reset and back-to-back divides.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall_divE;

  int total = 0;
  int bad   = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stall_divE (stall_divE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered one tick after a rising edge with the divider idle; leaves the
  // bench in the cycle after the ready pulse with start dropped.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] exp_res,
                         input int exp_lat);
    int cyc;
    int stall_cnt;
    cyc        = 0;
    stall_cnt  = 0;
    signed_div = sgn;
    a          = av;
    b          = bv;
    start      = 1'b1;
    #1;
    while (!ready && cyc < 40) begin
      if (stall_divE) stall_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_ready"},   64'(ready), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_result"},  result, exp_res);
    check({tag, "_stall_at_ready"}, 64'(stall_divE), 64'd0);
    check({tag, "_stall_cycles"},   64'(stall_cnt), 64'(exp_lat));
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    rst        = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    a          = '0;
    b          = '0;
    annul      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 64'd0);
    check("reset_ready",  64'(ready), 64'd0);
    check("reset_stall",  64'(stall_divE), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_div("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
    run_div("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
    run_div("div_by_0",   1'b0, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1);

    // annul at t+10, restart at t+12
    pulses     = 0;
    signed_div = 1'b0;
    a          = 32'd50;
    b          = 32'd5;
    start      = 1'b1;
    #1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (ready) pulses++;
      if (k == 4) begin
        a = 32'd999;
        b = 32'd1;
      end
    end
    annul = 1'b1;
    @(posedge clk);
    #1;
    if (ready) pulses++;
    annul = 1'b0;
    start = 1'b0;
    #1;
    check("annul_no_ready", 64'(pulses), 64'd0);
    check("annul_stall_low", 64'(stall_divE), 64'd0);
    @(posedge clk);
    #1;
    run_div("after_annul", 1'b0, 32'd60, 32'd7, {32'd4, 32'd8}, 33);

    // start and annul together in IDLE must not launch a divide
    signed_div = 1'b0;
    a          = 32'd81;
    b          = 32'd9;
    start      = 1'b1;
    annul      = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    run_div("start_with_annul", 1'b0, 32'd81, 32'd9, {32'd0, 32'd9}, 33);

    // reset in the middle of a divide
    signed_div = 1'b0;
    a          = 32'd1000;
    b          = 32'd3;
    start      = 1'b1;
    #1;
    repeat (5) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_result", result, 64'd0);
    check("midreset_ready",  64'(ready), 64'd0);
    check("midreset_stall",  64'(stall_divE), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_div("b2b_9_3",  1'b0, 32'd9,  32'd3, {32'd0, 32'd3}, 33);
    run_div("b2b_10_4", 1'b0, 32'd10, 32'd4, {32'd2, 32'd2}, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
